// File: rtl/aibcr3aux_seq_pkg.sv
// Shared state encoding and default timing constants for the AUX power-on/link-up sequencer.
package aibcr3aux_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_POR_WAIT = 3'd2,
        ST_STAGGER  = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    localparam int DEF_NUM_CH      = 24;
    localparam int DEF_DB_CYC      = 16;
    localparam int DEF_POR_WAIT    = 32;
    localparam int DEF_STAGGER_CYC = 4;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/aibcr3aux_sync2.sv
// Two-flop synchroniser for an asynchronous bump level; both stages clear to 0 on reset.
module aibcr3aux_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Metastability stage followed by the resolved stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/aibcr3aux_por_seq.sv
// AUX power-on/link-up sequencer: qualifies detect/POR, releases the POR override,
// then releases channel resets one at a time; any loss of qualification aborts to IDLE.
module aibcr3aux_por_seq
    import aibcr3aux_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DB_CYC      = DEF_DB_CYC,
    parameter int POR_WAIT    = DEF_POR_WAIT,
    parameter int STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              i_osc_clk,
    input  logic              i_rst,
    input  logic              i_device_detect,
    input  logic              i_por,
    input  logic              i_seq_hold,
    output logic              o_m_por_ovrd,
    output logic [NUM_CH-1:0] o_ch_rst_n,
    output logic              o_seq_ready,
    output logic [2:0]        o_seq_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  DB_TC    = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0]  PW_TC    = CNT_W'(POR_WAIT - 1);
    localparam logic [CNT_W-1:0]  ST_TC    = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1'b1);

    logic w_det_s;
    logic w_por_s;
    logic w_qual;

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_ovrd;
    logic              w_ovrd_nxt;
    logic [NUM_CH-1:0] r_ch_rst_n;
    logic [NUM_CH-1:0] w_ch_nxt;
    logic              r_ready;
    logic              w_ready_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    aibcr3aux_sync2 u_sync_det (
        .i_clk (i_osc_clk),
        .i_rst (i_rst),
        .i_d   (i_device_detect),
        .o_q   (w_det_s)
    );

    aibcr3aux_sync2 u_sync_por (
        .i_clk (i_osc_clk),
        .i_rst (i_rst),
        .i_d   (i_por),
        .o_q   (w_por_s)
    );

    assign w_qual = w_det_s & ~w_por_s;

    // Next-state, counter, index and output computation; abort takes priority over everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ovrd_nxt  = r_ovrd;
        w_ch_nxt    = r_ch_rst_n;
        w_ready_nxt = r_ready;

        if ((r_state != ST_IDLE) && !w_qual) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_ovrd_nxt  = 1'b1;
            w_ch_nxt    = '0;
            w_ready_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_idx_nxt   = '0;
                    w_ovrd_nxt  = 1'b1;
                    w_ch_nxt    = '0;
                    w_ready_nxt = 1'b0;
                    if (w_qual) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_cnt >= DB_TC) begin
                        w_state_nxt = ST_POR_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
                ST_POR_WAIT: begin
                    if (r_cnt >= PW_TC) begin
                        w_state_nxt = ST_STAGGER;
                        w_ovrd_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
                ST_STAGGER: begin
                    if (i_seq_hold) begin
                        w_cnt_nxt = r_cnt;
                    end else if (r_cnt >= ST_TC) begin
                        // Release the current channel; the last one completes the sequence
                        w_ch_nxt  = r_ch_rst_n | (CH_ONE << r_idx);
                        w_cnt_nxt = '0;
                        if (r_idx >= IDX_LAST) begin
                            w_state_nxt = ST_DONE;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_ONE;
                        end
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ovrd_nxt  = 1'b1;
                    w_ch_nxt    = '0;
                    w_ready_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge i_osc_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ovrd     <= 1'b1;
            r_ch_rst_n <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_ovrd     <= w_ovrd_nxt;
            r_ch_rst_n <= w_ch_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign o_m_por_ovrd = r_ovrd;
    assign o_ch_rst_n   = r_ch_rst_n;
    assign o_seq_ready  = r_ready;
    assign o_seq_state  = r_state;

endmodule

// File: tb/tb_aibcr3aux_por_seq.sv
// Scoreboard bench: a phase/elapsed-time model predicts the outputs after each edge;
// a monitor pops and compares one expectation per clock.
module tb_aibcr3aux_por_seq;

    localparam int NUM_CH      = 24;
    localparam int DB_CYC      = 16;
    localparam int POR_WAIT    = 32;
    localparam int STAGGER_CYC = 4;

    localparam int P_IDLE = 0;
    localparam int P_DEB  = 1;
    localparam int P_PW   = 2;
    localparam int P_STG  = 3;
    localparam int P_DONE = 4;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_det;
    logic              i_por;
    logic              i_hold;
    logic              o_ovrd;
    logic [NUM_CH-1:0] o_ch;
    logic              o_rdy;
    logic [2:0]        o_st;

    always #5 clk = ~clk;

    aibcr3aux_por_seq dut (
        .i_osc_clk       (clk),
        .i_rst           (i_rst),
        .i_device_detect (i_det),
        .i_por           (i_por),
        .i_seq_hold      (i_hold),
        .o_m_por_ovrd    (o_ovrd),
        .o_ch_rst_n      (o_ch),
        .o_seq_ready     (o_rdy),
        .o_seq_state     (o_st)
    );

    typedef struct packed {
        logic [2:0]        st;
        logic              ovrd;
        logic [NUM_CH-1:0] ch;
        logic              rdy;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase, edge of phase entry, and non-held stagger cycles
    int m_ph   = P_IDLE;
    int m_prog = 0;
    int m_cyc  = 0;
    int m_tent = 0;
    bit h_d0 = 1'b0, h_d1 = 1'b0, h_p0 = 1'b0, h_p1 = 1'b0;

    function automatic obs_t model_out();
        obs_t o;
        int   rel;
        o.st   = 3'(m_ph);
        o.ovrd = (m_ph == P_IDLE) || (m_ph == P_DEB) || (m_ph == P_PW);
        o.rdy  = (m_ph == P_DONE);
        o.ch   = '0;
        if (m_ph == P_DONE) begin
            o.ch = '1;
        end else if (m_ph == P_STG) begin
            rel = m_prog / STAGGER_CYC;
            for (int k = 0; k < NUM_CH; k++) o.ch[k] = (k < rel);
        end
        return o;
    endfunction

    function automatic void model_step(input bit rst, input bit det, input bit por, input bit hold);
        bit qual;
        m_cyc = m_cyc + 1;
        if (rst) begin
            h_d0 = 1'b0; h_d1 = 1'b0; h_p0 = 1'b0; h_p1 = 1'b0;
            m_ph = P_IDLE; m_prog = 0;
            return;
        end
        qual = h_d1 && !h_p1;
        h_d1 = h_d0; h_d0 = det;
        h_p1 = h_p0; h_p0 = por;
        if (m_ph != P_IDLE && !qual) begin
            m_ph = P_IDLE;
            m_prog = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (qual) begin m_ph = P_DEB; m_tent = m_cyc; end
                P_DEB:  if (m_cyc - m_tent == DB_CYC) begin m_ph = P_PW; m_tent = m_cyc; end
                P_PW:   if (m_cyc - m_tent == POR_WAIT) begin m_ph = P_STG; m_tent = m_cyc; m_prog = 0; end
                P_STG:  if (!hold) begin
                            m_prog = m_prog + 1;
                            if (m_prog / STAGGER_CYC == NUM_CH) m_ph = P_DONE;
                        end
                default: ;
            endcase
        end
    endfunction

    task automatic tick(input bit rst, input bit det, input bit por, input bit hold);
        @(negedge clk);
        i_rst  = rst;
        i_det  = det;
        i_por  = por;
        i_hold = hold;
        model_step(rst, det, por, hold);
        exp_q.push_back(model_out());
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {o_st, o_ovrd, o_ch, o_rdy};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got st=%0d ovrd=%b ch=%h rdy=%b exp st=%0d ovrd=%b ch=%h rdy=%b",
                             $time, got.st, got.ovrd, got.ch, got.rdy, e.st, e.ovrd, e.ch, e.rdy);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int unsigned r;
        i_rst = 1'b1; i_det = 1'b0; i_por = 1'b0; i_hold = 1'b0;

        // Straight power-up to DONE, then hold asserted in DONE
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 250 && m_ph != P_DONE; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b1, 1'b0, 1'b1);

        // One-cycle POR glitch around debounce count 10
        repeat (2) tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60 && !(m_ph == P_DEB && m_cyc - m_tent == 9); i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);

        // Abort in STAGGER after channel 5 is released
        for (int i = 0; i < 250 && !(m_ph == P_STG && m_prog / STAGGER_CYC >= 6); i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Seven hold cycles mid-stagger
        for (int i = 0; i < 250 && !(m_ph == P_STG && m_prog == 9); i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (7) tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 250 && m_ph != P_DONE; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset pulse in POR_WAIT, then in DONE
        for (int i = 0; i < 100 && !(m_ph == P_PW && m_cyc - m_tent == 5); i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 250 && m_ph != P_DONE; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Abort lands on the same edge as the final channel terminal count
        for (int i = 0; i < 300 && !(m_ph == P_STG && m_prog == NUM_CH * STAGGER_CYC - 3); i++)
            tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised detect drops, POR pulses, holds and resets
        repeat (3000) begin
            r = $urandom;
            tick((r % 32'd997) == 32'd0, ((r >> 10) % 32'd200) != 32'd0,
                 ((r >> 20) % 32'd300) == 32'd0, ((r >> 28) % 32'd8) == 32'd0);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
